// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } nsa_state_e;

    localparam int NIBBLE_W = 4;

    function automatic int nsa_cnt_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice, shared across all nibbles.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries are flattened so every c[i] depends only on g, p and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder computed one nibble per cycle, LSB first, on a single CLA slice.
// Optional subtraction (a - b) is enabled by defining NSA_SUB_EN.
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int KW  = nsa_cnt_w(NIB);
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    nsa_state_e state, state_next;

    logic [KW-1:0]     k;
    logic              c_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic              c_nib;
    logic              accept;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;

`ifdef NSA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (k == K_LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign a_nib = a_q[NIBBLE_W*int'(k) +: NIBBLE_W];
    assign b_nib = b_q[NIBBLE_W*int'(k) +: NIBBLE_W];

    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (c_q),
        .sum  (s_nib),
        .cout (c_nib)
    );

    // Operands carry no reset: they are always loaded before RUN reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k     <= '0;
            c_q   <= 1'b0;
            sum_q <= '0;
        end else if (accept) begin
            k   <= '0;
            c_q <= cin_eff;
        end else if (state == RUN) begin
            sum_q[NIBBLE_W*int'(k) +: NIBBLE_W] <= s_nib;
            c_q <= c_nib;
            if (k != K_LAST) k <= k + KW'(1);
        end
    end

    assign sum  = sum_q;
    assign cout = c_q;

endmodule
